// File: rtl/s2p_arbiter.sv
// s2p_arbiter: round-robin arbiter that feeds beat pairs from N_REQ requesters into one shared
// serial-to-parallel packer. Defining S2P_ARB_TIMEOUT_EN adds a second-beat timeout that flushes the pair.

module s2p_arbiter #(
   parameter int DATA_W  = 32,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     abort,
   output logic [DATA_W-1:0]        s2p_data,
   output logic                     s2p_valid,
   output logic                     s2p_clear,
   output logic [$clog2(N_REQ)-1:0] o_src,
   output logic                     o_pair_done,
   output logic                     o_drop
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CW    = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, FIRST, SECOND, FLUSH} state_t;

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] rr_pick;
   logic [IDX_W-1:0] src_q;
   logic [CW-1:0]    cand;
   logic             rr_found;
   logic             busy;
   logic             beat;
   logic             timeout_hit;
   logic             pair_done_q;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
      $error("s2p_arbiter: N_REQ must be 2..8 and TIMEOUT 2..255");
   end

   // Handshake: a beat moves when req_valid[k] and req_ready[k] are both high in the same cycle;
   // req_ready follows req_valid combinationally for the granted requester only.
   assign busy = (state == FIRST || state == SECOND) && !rst;
   assign beat = busy && req_valid[grant] && !abort;

   // Round-robin search starting just after the previous owner.
   always_comb begin
      rr_pick  = last_grant;
      rr_found = 1'b0;
      cand     = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = CW'(last_grant) + CW'(i);
         if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
         if (!rr_found && req_valid[cand[IDX_W-1:0]]) begin
            rr_found = 1'b1;
            rr_pick  = cand[IDX_W-1:0];
         end
      end
   end

`ifdef S2P_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] idle_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (state == FIRST && beat) begin
         idle_cnt <= '0;
      end else if (state == SECOND && !beat) begin
         idle_cnt <= idle_cnt + 8'd1;
      end
   end

   // A beat in the expiry cycle wins, so the check is gated by !beat.
   assign timeout_hit = (state == SECOND) && !beat && !abort && (idle_cnt == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      next_state       = state;
      req_ready        = '0;
      req_ready[grant] = beat;
      s2p_valid        = beat;
      s2p_data         = req_data[grant*DATA_W +: DATA_W];
      s2p_clear        = rst || (state == FLUSH);
      o_drop           = (state == FLUSH) && !rst;
      case (state)
         IDLE: begin
            if (rr_found) next_state = FIRST;
         end
         FIRST: begin
            if (abort)     next_state = FLUSH;
            else if (beat) next_state = SECOND;
         end
         SECOND: begin
            if (abort)            next_state = FLUSH;
            else if (beat)        next_state = IDLE;
            else if (timeout_hit) next_state = FLUSH;
         end
         FLUSH: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         last_grant  <= IDX_W'(N_REQ - 1);
         src_q       <= '0;
         pair_done_q <= 1'b0;
      end else begin
         state       <= next_state;
         pair_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (rr_found) grant <= rr_pick;
            end
            SECOND: begin
               if (beat) begin
                  last_grant  <= grant;
                  src_q       <= grant;
                  pair_done_q <= 1'b1;
               end
            end
            FLUSH: begin
               last_grant <= grant;
            end
            default: ;
         endcase
      end
   end

   assign o_src       = src_q;
   assign o_pair_done = pair_done_q;

endmodule

// File: tb/tb_s2p_arbiter.sv
// Bench for s2p_arbiter: directed vector table, hand-written pair/stall/timeout sequences, and
// randomized traffic checked against a pair-ownership reference model with a data scoreboard.

module tb_s2p_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int TO = 4;
`ifdef S2P_ARB_TIMEOUT_EN
   localparam int STALL = 3;
`else
   localparam int STALL = 5;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]  req_valid = '0;
   logic [NR-1:0]  req_ready;
   logic           abort = 1'b0;
   logic [DW-1:0]  s2p_data;
   logic           s2p_valid;
   logic           s2p_clear;
   logic [1:0]     o_src;
   logic           o_pair_done;
   logic           o_drop;

   int n_chk = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q[$];

   typedef struct {
      logic       r;
      logic [3:0] v;
      logic       a;
      logic [3:0] rdy;
      logic       clr;
      logic       drp;
      logic       done;
      logic       sc;
      logic [1:0] src;
   } vec_t;
   vec_t tbl[$];

   s2p_arbiter #(.DATA_W(DW), .N_REQ(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
      .abort(abort), .s2p_data(s2p_data), .s2p_valid(s2p_valid), .s2p_clear(s2p_clear),
      .o_src(o_src), .o_pair_done(o_pair_done), .o_drop(o_drop)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic drive(input logic r, input logic [3:0] v, input logic a);
      @(posedge clk);
      #1;
      rst = r; req_valid = v; abort = a;
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b1, 4'h0, 1'b0);
      drive(1'b1, 4'h0, 1'b0);
   endtask

   function automatic void add(input logic r, input logic [3:0] v, input logic a, input logic [3:0] rdy,
                               input logic clr, input logic drp, input logic done, input logic sc,
                               input logic [1:0] src);
      vec_t e;
      e.r = r; e.v = v; e.a = a; e.rdy = rdy; e.clr = clr;
      e.drp = drp; e.done = done; e.sc = sc; e.src = src;
      tbl.push_back(e);
   endfunction

   task automatic run_table();
      logic [DW-1:0] ed;
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].v, tbl[i].a);
         chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), s2p_valid, |tbl[i].rdy);
         chk($sformatf("tbl%0d_clear", i), s2p_clear, tbl[i].clr);
         chk($sformatf("tbl%0d_drop", i), o_drop, tbl[i].drp);
         chk($sformatf("tbl%0d_done", i), o_pair_done, tbl[i].done);
         if (tbl[i].sc) chk($sformatf("tbl%0d_src", i), o_src, tbl[i].src);
         if (|tbl[i].rdy) begin
            ed = '0;
            for (int k = 0; k < NR; k++) if (tbl[i].rdy[k]) ed = 8'hA0 + 8'(k);
            chk($sformatf("tbl%0d_data", i), s2p_data, ed);
         end
      end
   endtask

   task automatic seq_stall();
      do_reset();
      req_data = {8'h0A, 24'h0};
      drive(1'b0, 4'h8, 1'b0);
      chk("stall_idle_valid", s2p_valid, 0);
      drive(1'b0, 4'h8, 1'b0);
      chk("stall_b1_ready", req_ready, 4'h8);
      chk("stall_b1_data", s2p_data, 8'h0A);
      for (int i = 0; i < STALL; i++) begin
         drive(1'b0, 4'h0, 1'b0);
         chk("stall_gap_valid", s2p_valid, 0);
         chk("stall_gap_drop", o_drop, 0);
      end
      req_data = {8'h0B, 24'h0};
      drive(1'b0, 4'h8, 1'b0);
      chk("stall_b2_valid", s2p_valid, 1);
      chk("stall_b2_data", s2p_data, 8'h0B);
      drive(1'b0, 4'h0, 1'b0);
      chk("stall_done", o_pair_done, 1);
      chk("stall_src", o_src, 3);
      chk("stall_nodrop", o_drop, 0);
   endtask

   task automatic seq_timeout();
      do_reset();
      drive(1'b0, 4'h1, 1'b0);
      drive(1'b0, 4'h1, 1'b0);
      chk("to_b1_valid", s2p_valid, 1);
`ifdef S2P_ARB_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         drive(1'b0, 4'h0, 1'b0);
         chk("to_wait_drop", o_drop, 0);
      end
      drive(1'b0, 4'h0, 1'b0);
      chk("to_flush_drop", o_drop, 1);
      chk("to_flush_clear", s2p_clear, 1);
      drive(1'b0, 4'h0, 1'b0);
      chk("to_after_drop", o_drop, 0);
      chk("to_after_clear", s2p_clear, 0);
      // Second beat lands exactly in the expiry cycle.
      do_reset();
      drive(1'b0, 4'h1, 1'b0);
      drive(1'b0, 4'h1, 1'b0);
      for (int i = 0; i < TO - 1; i++) drive(1'b0, 4'h0, 1'b0);
      drive(1'b0, 4'h1, 1'b0);
      chk("to_edge_ready", req_ready, 4'h1);
      drive(1'b0, 4'h0, 1'b0);
      chk("to_edge_done", o_pair_done, 1);
      chk("to_edge_drop", o_drop, 0);
      drive(1'b0, 4'h0, 1'b0);
      chk("to_edge_drop2", o_drop, 0);
`else
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, 4'h0, 1'b0);
         chk("noto_drop", o_drop, 0);
      end
      drive(1'b0, 4'h1, 1'b0);
      chk("noto_b2_ready", req_ready, 4'h1);
      drive(1'b0, 4'h0, 1'b0);
      chk("noto_done", o_pair_done, 1);
`endif
   endtask

   // Reference model: who owns the packer, how many beats it has delivered, and whether a
   // discard is pending; outputs follow from those facts and the current inputs.
   task automatic rand_phase(input int cycles);
      int owner, beats, last, src, idle;
      bit done, flush, found;
      logic [3:0] v, erdy;
      logic a;
      do_reset();
      owner = -1; beats = 0; last = NR - 1; src = 0; idle = 0; done = 0; flush = 0;
      for (int c = 0; c < cycles; c++) begin
         v = 4'($urandom_range(0, 15));
         a = ($urandom_range(0, 19) == 0);
         req_data = $urandom;
         drive(1'b0, v, a);
         erdy = '0;
         if (owner >= 0 && !flush && v[owner] && !a) erdy[owner] = 1'b1;
         if (|erdy) exp_q.push_back(req_data[owner*DW +: DW]);
         chk("rnd_ready", req_ready, erdy);
         chk("rnd_valid", s2p_valid, |erdy);
         chk("rnd_clear", s2p_clear, flush);
         chk("rnd_drop", o_drop, flush);
         chk("rnd_done", o_pair_done, done);
         chk("rnd_src", o_src, src);
         if (s2p_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL rnd_data: got beat 0x%0h expected no beat at %0t", s2p_data, $time);
            end else begin
               chk("rnd_data", s2p_data, exp_q.pop_front());
            end
         end
         done = 0;
         if (flush) begin
            flush = 0; last = owner; owner = -1;
         end else if (owner < 0) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
               if (!found && v[(last + k) % NR]) begin
                  found = 1; owner = (last + k) % NR;
               end
            end
            beats = 0;
         end else if (a) begin
            flush = 1;
         end else if (|erdy) begin
            if (beats == 0) begin
               beats = 1; idle = 0;
            end else begin
               done = 1; src = owner; last = owner; owner = -1;
            end
         end else if (beats == 1) begin
            idle++;
`ifdef S2P_ARB_TIMEOUT_EN
            if (idle == TO) flush = 1;
`endif
         end
      end
      chk("rnd_sb_drain", exp_q.size(), 0);
   endtask

   initial begin
      // r, v, a | ready, clear, drop, done, src_checked, src
      add(1, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0);
      add(1, 4'h0, 0, 4'h0, 1, 0, 0, 1, 0);
      // Requesters 1 and 2 continuously: pairs alternate 1,2,1,2 every 3 cycles.
      add(0, 4'h6, 0, 4'h0, 0, 0, 0, 1, 0);
      add(0, 4'h6, 0, 4'h2, 0, 0, 0, 1, 0);
      add(0, 4'h6, 0, 4'h2, 0, 0, 0, 1, 0);
      add(0, 4'h6, 0, 4'h0, 0, 0, 1, 1, 1);
      add(0, 4'h6, 0, 4'h4, 0, 0, 0, 1, 1);
      add(0, 4'h6, 0, 4'h4, 0, 0, 0, 1, 1);
      add(0, 4'h6, 0, 4'h0, 0, 0, 1, 1, 2);
      add(0, 4'h6, 0, 4'h2, 0, 0, 0, 1, 2);
      add(0, 4'h6, 0, 4'h2, 0, 0, 0, 1, 2);
      add(0, 4'h6, 0, 4'h0, 0, 0, 1, 1, 1);
      add(0, 4'h6, 0, 4'h4, 0, 0, 0, 1, 1);
      add(0, 4'h6, 0, 4'h4, 0, 0, 0, 1, 1);
      add(0, 4'h6, 0, 4'h0, 0, 0, 1, 1, 2);
      // Reset while requester 1 owns the packer.
      add(1, 4'h6, 0, 4'h0, 1, 0, 0, 1, 2);
      add(1, 4'h6, 0, 4'h0, 1, 0, 0, 1, 0);
      // Abort on requester 0's second beat, then requester 1 wins.
      add(0, 4'h3, 0, 4'h0, 0, 0, 0, 1, 0);
      add(0, 4'h3, 0, 4'h1, 0, 0, 0, 1, 0);
      add(0, 4'h3, 1, 4'h0, 0, 0, 0, 1, 0);
      add(0, 4'h3, 1, 4'h0, 1, 1, 0, 1, 0);
      add(0, 4'h3, 0, 4'h0, 0, 0, 0, 1, 0);
      add(0, 4'h3, 0, 4'h2, 0, 0, 0, 1, 0);
      add(0, 4'h3, 0, 4'h2, 0, 0, 0, 1, 0);
      add(0, 4'h1, 0, 4'h0, 0, 0, 1, 1, 1);
      add(0, 4'h1, 0, 4'h1, 0, 0, 0, 1, 1);
      // Reset in SECOND: partial pair discarded, no drop pulse, clear released after reset.
      add(0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 1);
      add(1, 4'h0, 0, 4'h0, 1, 0, 0, 1, 1);
      add(1, 4'h0, 0, 4'h0, 1, 0, 0, 1, 0);
      add(0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 0);

      run_table();
      seq_stall();
      seq_timeout();
      rand_phase(400);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
